// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB3 requester: turns a valid/ready command into one
// SETUP/ACCESS transfer and returns one response, with an optional pready watchdog.
module apb_master_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic       pclk,
    input  logic       preset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       rsp_timeout,
    output logic       busy,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    input  logic       pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       cmd_ready_q, cmd_ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_err_q, rsp_err_d;
    logic       rsp_timeout_q, rsp_timeout_d;
    logic       busy_q, busy_d;
    logic       psel_q, psel_d;
    logic       penable_q, penable_d;
    logic       pwrite_q, pwrite_d;
    logic [7:0] paddr_q, paddr_d;
    logic [7:0] pwdata_q, pwdata_d;

    logic accept, done, abort;

    assign accept = cmd_valid && cmd_ready_q;
    assign done   = (state_q == ACCESS) && pready;
    // pready has priority over the watchdog on the same edge
    assign abort  = (state_q == ACCESS) && !pready && TIMEOUT_EN && (cnt_q == CNT_LAST);

    // State and output registers
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 8'h00;
            pwdata_q      <= 8'h00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
            busy_q        <= busy_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
        end
    end

    // Next state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (done || abort) state_d = IDLE;
                else               cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs decoded from the upcoming state plus transfer events
    always_comb begin
        cmd_ready_d   = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        psel_d        = (state_d != IDLE);
        penable_d     = (state_d == ACCESS);
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        if (accept) begin
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_write ? cmd_wdata : 8'h00;
        end

        if (done) begin
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = pwrite_q ? 8'h00 : prdata;
            rsp_err_d     = pslverr;
            rsp_timeout_d = 1'b0;
        end else if (abort) begin
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = 8'h00;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign busy        = busy_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: cycle-count transfer model checked every cycle,
// plus directed transactions with hand-computed latency and response values.
module tb_apb_master_ctrl;

    localparam int T = 16;

    logic       pclk = 1'b0;
    logic       preset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       busy;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int checks = 0;
    int errors = 0;

    // Slave behaviour knobs
    int         slv_wait  = 0;
    logic [7:0] slv_rdata = 8'h00;
    logic       slv_err   = 1'b0;
    int         acc_cnt   = 0;

    always #5 pclk = ~pclk;

    apb_master_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout), .busy(busy),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // Simple APB slave: ready after slv_wait extra ACCESS cycles
    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n)            acc_cnt <= 0;
        else if (psel && penable) acc_cnt <= acc_cnt + 1;
        else                      acc_cnt <= 0;
    end
    assign pready  = psel && penable && (acc_cnt == slv_wait);
    assign prdata  = slv_rdata;
    assign pslverr = slv_err;

    // Model: k = cycles since the accept edge (0 = no transfer in flight)
    int         m_k = 0;
    logic       m_rsp_valid = 1'b0;
    logic [7:0] m_rdata = 8'h00;
    logic       m_err = 1'b0;
    logic       m_to = 1'b0;
    logic       m_pwrite = 1'b0;
    logic [7:0] m_paddr = 8'h00;
    logic [7:0] m_pwdata = 8'h00;

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            m_k <= 0; m_rsp_valid <= 1'b0; m_rdata <= 8'h00; m_err <= 1'b0; m_to <= 1'b0;
            m_pwrite <= 1'b0; m_paddr <= 8'h00; m_pwdata <= 8'h00;
        end else begin
            m_rsp_valid <= 1'b0;
            if (m_k == 0) begin
                if (cmd_valid) begin
                    m_k      <= 1;
                    m_pwrite <= cmd_write;
                    m_paddr  <= cmd_addr;
                    m_pwdata <= cmd_write ? cmd_wdata : 8'h00;
                end
            end else if (m_k == 1) begin
                m_k <= 2;
            end else if (pready) begin
                m_k <= 0; m_rsp_valid <= 1'b1;
                m_rdata <= m_pwrite ? 8'h00 : prdata;
                m_err <= pslverr; m_to <= 1'b0;
            end else if (T != 0 && (m_k - 1) == T) begin
                m_k <= 0; m_rsp_valid <= 1'b1;
                m_rdata <= 8'h00; m_err <= 1'b1; m_to <= 1'b1;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge pclk) begin
        chk("cyc_cmd_ready", 32'(cmd_ready), 32'(m_k == 0));
        chk("cyc_busy",      32'(busy),      32'(m_k >= 1));
        chk("cyc_psel",      32'(psel),      32'(m_k >= 1));
        chk("cyc_penable",   32'(penable),   32'(m_k >= 2));
        chk("cyc_rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
        chk("cyc_rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        chk("cyc_rsp_err",   32'(rsp_err),   32'(m_err));
        chk("cyc_rsp_to",    32'(rsp_timeout), 32'(m_to));
        chk("cyc_pwrite",    32'(pwrite),    32'(m_pwrite));
        chk("cyc_paddr",     32'(paddr),     32'(m_paddr));
        chk("cyc_pwdata",    32'(pwdata),    32'(m_pwdata));
    end

    task automatic run_txn(input string nm, input logic w, input logic [7:0] a, input logic [7:0] d,
                           input int wt, input logic [7:0] srd, input logic serr,
                           input int exp_lat, input int exp_acc,
                           input logic [7:0] exp_rd, input logic exp_err, input logic exp_to);
        int n;
        int acc;
        slv_wait = wt; slv_rdata = srd; slv_err = serr;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(posedge pclk); #1; n++; end
        chk({nm, "_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge pclk); #1;
        // Junk on the command port must not disturb the transfer
        cmd_valid = 1'b0; cmd_addr = 8'hEE; cmd_wdata = 8'hEE; cmd_write = ~w;
        n = 0; acc = 0;
        while (!rsp_valid && n < 100) begin
            if (psel && penable) acc++;
            @(posedge pclk); #1; n++;
        end
        chk({nm, "_latency"}, 32'(n + 1), 32'(exp_lat));
        chk({nm, "_access_cycles"}, 32'(acc), 32'(exp_acc));
        chk({nm, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
        chk({nm, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({nm, "_timeout"}, 32'(rsp_timeout), 32'(exp_to));
        chk({nm, "_psel_done"}, 32'(psel), 32'd0);
        chk({nm, "_paddr"}, 32'(paddr), 32'(a));
        chk({nm, "_pwrite"}, 32'(pwrite), 32'(w));
        chk({nm, "_pwdata"}, 32'(pwdata), 32'(w ? d : 8'h00));
        @(posedge pclk); #1;
        chk({nm, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
        slv_err = 1'b0;
    endtask

    initial begin
        logic [7:0] b2b_addr [3];
        logic [7:0] b2b_data [3];
        int idx, cyc, low, rsps, bad;
        logic acc_now;
        b2b_addr[0] = 8'h00; b2b_addr[1] = 8'h01; b2b_addr[2] = 8'h02;
        b2b_data[0] = 8'h11; b2b_data[1] = 8'h22; b2b_data[2] = 8'h33;

        repeat (2) @(posedge pclk);
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_psel", 32'(psel), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        preset_n = 1'b1;
        @(posedge pclk); #1;

        run_txn("wr_w2",   1'b1, 8'h01, 8'hB5, 2,    8'hAA, 1'b0, 5,  3,  8'h00, 1'b0, 1'b0);
        run_txn("rd_w0",   1'b0, 8'h00, 8'h77, 0,    8'h5A, 1'b0, 3,  1,  8'h5A, 1'b0, 1'b0);
        run_txn("rd_err",  1'b0, 8'h07, 8'h00, 0,    8'h3C, 1'b1, 3,  1,  8'h3C, 1'b1, 1'b0);
        run_txn("rd_to",   1'b0, 8'h10, 8'h00, 1000, 8'hFF, 1'b0, 18, 16, 8'h00, 1'b1, 1'b1);
        run_txn("rd_edge", 1'b0, 8'h11, 8'h00, 15,   8'h99, 1'b0, 18, 16, 8'h99, 1'b0, 1'b0);

        // Back-to-back writes with cmd_valid held high
        slv_wait = 0;
        cmd_write = 1'b1; cmd_addr = b2b_addr[0]; cmd_wdata = b2b_data[0]; cmd_valid = 1'b1;
        @(posedge pclk); #1;
        idx = 1; cmd_addr = b2b_addr[1]; cmd_wdata = b2b_data[1];
        cyc = 0; low = 0; rsps = 0; bad = 0;
        while (rsps < 3 && cyc < 40) begin
            cyc++;
            if (!psel) low++;
            if (rsp_valid) rsps++;
            if (busy && cmd_ready) bad++;
            acc_now = cmd_valid && cmd_ready;
            @(posedge pclk); #1;
            if (acc_now) begin
                idx++;
                if (idx < 3) begin cmd_addr = b2b_addr[idx]; cmd_wdata = b2b_data[idx]; end
                else cmd_valid = 1'b0;
            end
        end
        chk("b2b_rsp_pulses", 32'(rsps), 32'd3);
        chk("b2b_psel_low", 32'(low), 32'd3);
        chk("b2b_cycles", 32'(cyc), 32'd9);
        chk("b2b_ready_while_busy", 32'(bad), 32'd0);
        chk("b2b_last_paddr", 32'(paddr), 32'h02);
        chk("b2b_last_pwdata", 32'(pwdata), 32'h33);

        // Reset in the middle of ACCESS
        slv_wait = 1000;
        cmd_write = 1'b0; cmd_addr = 8'h20; cmd_valid = 1'b1;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        repeat (3) begin @(posedge pclk); #1; end
        chk("rst_pre_penable", 32'(penable), 32'd1);
        #2 preset_n = 1'b0;
        #1;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(posedge pclk);
        #1;
        chk("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
        preset_n = 1'b1;
        @(posedge pclk); #1;
        run_txn("post_rst", 1'b1, 8'h05, 8'h6C, 1, 8'h00, 1'b0, 4, 2, 8'h00, 1'b0, 1'b0);

        repeat (3) @(posedge pclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
Single-outstanding APB3 requester that converts a simple valid/ready command port into APB SETUP/ACCESS transfers on an 8-bit address/data bus. It drives the register-block slaves (timer TDR/TCR/TSR etc.) from the interrupt-handler/CPU-side logic. It returns one response per command, carrying read data, slave error and timeout status. A watchdog aborts transfers whose slave never asserts pready.

Parameters:
TIMEOUT_CYCLES, 16, max ACCESS-phase cycles waiting for pready before abort; 0 disables timeout
CNT_W, 5, width of the wait counter; must hold TIMEOUT_CYCLES

Ports:
pclk  input  1  APB clock, all logic on rising edge
preset_n  input  1  reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at posedge
cmd_write  input  1  1=write, 0=read
cmd_addr  input  8  target address
cmd_wdata  input  8  write data
rsp_valid  output  1  one-cycle response strobe
rsp_rdata  output  8  read data, valid with rsp_valid
rsp_err  output  1  pslverr or timeout, valid with rsp_valid
rsp_timeout  output  1  abort due to timeout, valid with rsp_valid
busy  output  1  transfer in SETUP or ACCESS
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  8  APB address
pwdata  output  8  APB write data
prdata  input  8  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- Reset: preset_n asynchronous, active-low; clock pclk. All outputs 0 except cmd_ready=1; FSM=IDLE; counter=0. Reset mid-transfer drops psel/penable immediately; no response is issued for the aborted command.
- FSM states: IDLE, SETUP, ACCESS. All outputs registered.
- IDLE: cmd_ready=1. On accept, register cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata (pwdata=0 for reads); next state SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, cmd_ready=0, busy=1; next state ACCESS; counter cleared.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata held stable. At each posedge:
  - pready=1 -> capture rsp_rdata=prdata (reads; 0 for writes), rsp_err=pslverr, rsp_timeout=0; next state IDLE.
  - pready=0 and TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 -> abort: rsp_rdata=0, rsp_err=1, rsp_timeout=1; next state IDLE.
  - else counter+1, stay in ACCESS.
- Completion cycle (first IDLE cycle after ACCESS): psel=0, penable=0, rsp_valid=1 for exactly one cycle, cmd_ready=1. A command accepted in this cycle enters SETUP next cycle (back-to-back; psel low for exactly 1 cycle between transfers).
- pready and timeout on the same edge: pready wins (normal completion).
- pslverr is sampled only when pready=1 in ACCESS; ignored otherwise. prdata ignored for writes.
- Latency: accept edge N; SETUP cycle N+1; ACCESS from N+2; with W wait states, rsp_valid in cycle N+3+W.
- paddr/pwrite/pwdata hold last values between transfers; rsp_rdata/rsp_err/rsp_timeout hold until the next response.
- cmd_* changes while not accepted have no effect; at most one transfer outstanding.

Test Plan:
- Write addr 0x01 data 0xB5, slave 2 wait states -> SETUP 1 cycle, ACCESS 3 cycles with paddr=0x01/pwdata=0xB5 stable; rsp_valid 1 cycle, rsp_err=0, rsp_rdata=0x00.
- Read addr 0x00, slave returns 0x5A with pready in first ACCESS cycle -> rsp_valid 3 cycles after accept, rsp_rdata=0x5A, pwdata=0x00, pwrite=0.
- Read addr 0x07, slave returns pslverr=1 with pready -> rsp_err=1, rsp_timeout=0; next command is accepted normally.
- Slave never asserts pready, TIMEOUT_CYCLES=16 -> exactly 16 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0x00; pready arriving on the 16th edge -> normal completion instead.
- cmd_valid held high for 3 writes (0x00/0x11, 0x01/0x22, 0x02/0x33), zero wait states -> psel low exactly 1 cycle between transfers, 3 rsp_valid pulses, cmd_ready low during SETUP/ACCESS.
- preset_n asserted during ACCESS -> psel/penable/busy drop asynchronously, no rsp_valid, cmd_ready=1; a new command after release completes normally.
